// File: rtl/decode_hazard_tracker_if.sv
// Decode-stage bundle between the decoder/control unit and the hazard tracker.
// The master side drives the decoded fields; the slave side returns the forwarding selects and stall.
interface decode_hazard_tracker_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 32
) ();
    logic                  DATA_CACHE_READY;
    logic                  INS_CACHE_READY;
    logic                  FLUSH;
    logic                  DEC_VALID;
    logic [REG_ADDR_W-1:0] RS1_SEL;
    logic [REG_ADDR_W-1:0] RS2_SEL;
    logic                  RS1_USED;
    logic                  RS2_USED;
    logic [REG_ADDR_W-1:0] RD_IN;
    logic [1:0]            TYPE_IN;
    logic [SEL_W-1:0]      MUX1_SELECT;
    logic [SEL_W-1:0]      MUX2_SELECT;
    logic [1:0]            RS1_TYPE;
    logic [1:0]            RS2_TYPE;
    logic                  STALL_ENABLE;
    logic [CNT_W-1:0]      STALL_COUNT;

    modport master (
        output DATA_CACHE_READY, INS_CACHE_READY, FLUSH, DEC_VALID,
        output RS1_SEL, RS2_SEL, RS1_USED, RS2_USED, RD_IN, TYPE_IN,
        input  MUX1_SELECT, MUX2_SELECT, RS1_TYPE, RS2_TYPE, STALL_ENABLE, STALL_COUNT
    );

    modport slave (
        input  DATA_CACHE_READY, INS_CACHE_READY, FLUSH, DEC_VALID,
        input  RS1_SEL, RS2_SEL, RS1_USED, RS2_USED, RD_IN, TYPE_IN,
        output MUX1_SELECT, MUX2_SELECT, RS1_TYPE, RS2_TYPE, STALL_ENABLE, STALL_COUNT
    );
endinterface

// File: rtl/decode_hazard_tracker.sv
// Tracks in-flight destination registers behind decode, picks forwarding sources per operand,
// detects load-use hazards and counts the advancing cycles spent stalled.
module decode_hazard_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    decode_hazard_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        TYPE_IDLE  = 2'd0,
        TYPE_ALU   = 2'd1,
        TYPE_LOAD  = 2'd2,
        TYPE_STORE = 2'd3
    } op_type_e;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [1:0]       op;
        logic             hazard;
    } fwd_t;

    logic                  entry_valid  [DEPTH];
    op_type_e              entry_type   [DEPTH];
    logic [REG_ADDR_W-1:0] entry_rd     [DEPTH];
    logic                  entry_writes [DEPTH];
    logic [CNT_W-1:0]      stall_count;

    fwd_t fwd1;
    fwd_t fwd2;
    logic advance;
    logic stall_enable;
    logic accept;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_writes[i] = entry_valid[i]
                           && (entry_type[i] == TYPE_ALU || entry_type[i] == TYPE_LOAD)
                           && (entry_rd[i] != '0);
        end
    end

    // Scanning oldest to youngest lets the youngest writer overwrite the result; non-writers never match.
    function automatic fwd_t lookup(input logic used, input logic [REG_ADDR_W-1:0] src);
        fwd_t r;
        r = '0;
        if (used && src != '0) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entry_writes[i] && entry_rd[i] == src) begin
                    r.sel    = SEL_W'(i + 1);
                    r.op     = entry_type[i];
                    r.hazard = (entry_type[i] == TYPE_LOAD) && (i < LOAD_LAT);
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1         = lookup(bus.RS1_USED, bus.RS1_SEL);
        fwd2         = lookup(bus.RS2_USED, bus.RS2_SEL);
        advance      = bus.DATA_CACHE_READY & bus.INS_CACHE_READY;
        stall_enable = !(fwd1.hazard || fwd2.hazard) || bus.FLUSH;
        accept       = bus.DEC_VALID & stall_enable & !bus.FLUSH;
    end

    assign bus.MUX1_SELECT  = fwd1.sel;
    assign bus.MUX2_SELECT  = fwd2.sel;
    assign bus.RS1_TYPE     = fwd1.op;
    assign bus.RS2_TYPE     = fwd2.op;
    assign bus.STALL_ENABLE = stall_enable;
    assign bus.STALL_COUNT  = stall_count;

    // Shift on advance with a bubble injected when decode is held or killed; a frozen flush only clears entry 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_valid[i] <= 1'b0;
                entry_type[i]  <= TYPE_IDLE;
                entry_rd[i]    <= '0;
            end
            stall_count <= '0;
        end else if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entry_valid[i] <= entry_valid[i-1];
                entry_type[i]  <= entry_type[i-1];
                entry_rd[i]    <= entry_rd[i-1];
            end
            entry_valid[0] <= accept;
            entry_type[0]  <= accept ? op_type_e'(bus.TYPE_IN) : TYPE_IDLE;
            entry_rd[0]    <= accept ? bus.RD_IN : '0;
            if (!stall_enable && bus.DEC_VALID && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end else if (bus.FLUSH) begin
            entry_valid[0] <= 1'b0;
            entry_type[0]  <= TYPE_IDLE;
            entry_rd[0]    <= '0;
        end
    end

endmodule

// File: tb/tb_decode_hazard_tracker.sv
// Scoreboard bench for decode_hazard_tracker: directed decode sequences push expected outputs,
// a negedge monitor pops and compares; a 2-bit-counter twin checks saturation.
module tb_decode_hazard_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic strobe = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decode_hazard_tracker_if #(.REG_ADDR_W(5), .SEL_W(3), .CNT_W(32)) dif ();
    decode_hazard_tracker_if #(.REG_ADDR_W(5), .SEL_W(3), .CNT_W(2))  sif ();

    assign sif.DATA_CACHE_READY = dif.DATA_CACHE_READY;
    assign sif.INS_CACHE_READY  = dif.INS_CACHE_READY;
    assign sif.FLUSH            = dif.FLUSH;
    assign sif.DEC_VALID        = dif.DEC_VALID;
    assign sif.RS1_SEL          = dif.RS1_SEL;
    assign sif.RS2_SEL          = dif.RS2_SEL;
    assign sif.RS1_USED         = dif.RS1_USED;
    assign sif.RS2_USED         = dif.RS2_USED;
    assign sif.RD_IN            = dif.RD_IN;
    assign sif.TYPE_IN          = dif.TYPE_IN;

    decode_hazard_tracker #(.REG_ADDR_W(5), .DEPTH(4), .LOAD_LAT(2), .SEL_W(3), .CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (dif)
    );

    decode_hazard_tracker #(.REG_ADDR_W(5), .DEPTH(4), .LOAD_LAT(2), .SEL_W(3), .CNT_W(2)) dut_sat (
        .CLK (clk),
        .RST (rst),
        .bus (sif)
    );

    typedef struct {
        logic       rdy_d;
        logic       rdy_i;
        logic       flush;
        logic       dv;
        logic [1:0] ty;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
    } vec_t;

    typedef struct {
        string       name;
        int unsigned s1;
        int unsigned t1;
        int unsigned s2;
        int unsigned t2;
        logic        se;
        int unsigned cnt;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t ins(input logic [1:0] ty, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2);
        vec_t v;
        v.rdy_d = 1'b1; v.rdy_i = 1'b1; v.flush = 1'b0; v.dv = 1'b1;
        v.ty = ty; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        return v;
    endfunction

    function automatic exp_t ex(input string nm, input int unsigned s1, input int unsigned t1,
                                input int unsigned s2, input int unsigned t2,
                                input logic se, input int unsigned cnt);
        exp_t e;
        e.name = nm; e.s1 = s1; e.t1 = t1; e.s2 = s2; e.t2 = t2; e.se = se; e.cnt = cnt;
        return e;
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [1:0] sat_exp;
        bit ok;
        sat_exp = (e.cnt > 3) ? 2'd3 : 2'(e.cnt);
        ok = (dif.MUX1_SELECT === 3'(e.s1)) && (dif.RS1_TYPE === 2'(e.t1))
          && (dif.MUX2_SELECT === 3'(e.s2)) && (dif.RS2_TYPE === 2'(e.t2))
          && (dif.STALL_ENABLE === e.se) && (dif.STALL_COUNT === 32'(e.cnt))
          && (sif.STALL_ENABLE === e.se) && (sif.STALL_COUNT === sat_exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got sel1=%0d t1=%0d sel2=%0d t2=%0d en=%0b cnt=%0d sat=%0d; expected sel1=%0d t1=%0d sel2=%0d t2=%0d en=%0b cnt=%0d sat=%0d",
                     e.name, dif.MUX1_SELECT, dif.RS1_TYPE, dif.MUX2_SELECT, dif.RS2_TYPE,
                     dif.STALL_ENABLE, dif.STALL_COUNT, sif.STALL_COUNT,
                     e.s1, e.t1, e.s2, e.t2, e.se, e.cnt, sat_exp);
        end
    endtask

    // Monitor: every strobed cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard: strobed output with empty queue, expected an entry");
            end else begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input bit chk, input exp_t e);
        @(posedge clk);
        #1;
        rst                  = 1'b0;
        dif.DATA_CACHE_READY = v.rdy_d;
        dif.INS_CACHE_READY  = v.rdy_i;
        dif.FLUSH            = v.flush;
        dif.DEC_VALID        = v.dv;
        dif.TYPE_IN          = v.ty;
        dif.RD_IN            = v.rd;
        dif.RS1_SEL          = v.rs1;
        dif.RS1_USED         = v.u1;
        dif.RS2_SEL          = v.rs2;
        dif.RS2_USED         = v.u2;
        if (chk) exp_q.push_back(e);
        strobe = chk;
    endtask

    task automatic doReset(output logic [4:0] last_rd);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            rst                  = 1'b1;
            last_rd              = 5'($urandom_range(1, 31));
            dif.DATA_CACHE_READY = 1'($urandom_range(0, 1));
            dif.INS_CACHE_READY  = 1'($urandom_range(0, 1));
            dif.FLUSH            = 1'($urandom_range(0, 1));
            dif.DEC_VALID        = 1'b1;
            dif.TYPE_IN          = 2'd1;
            dif.RD_IN            = last_rd;
            dif.RS1_SEL          = 5'($urandom_range(0, 31));
            dif.RS2_SEL          = 5'($urandom_range(0, 31));
            dif.RS1_USED         = 1'($urandom_range(0, 1));
            dif.RS2_USED         = 1'($urandom_range(0, 1));
            if (c == 1) exp_q.push_back(ex("reset_hold", 0, 0, 0, 0, 1'b1, 0));
            strobe = (c == 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [4:0] r;

        // Reset: nothing tracked afterwards, even the rd presented during reset
        doReset(r);
        v = ins(2'd0, 5'd0, r, 1'b1, r, 1'b1); v.dv = 1'b0;
        applyStimulus(v, 1, ex("reset_no_fwd", 0, 0, 0, 0, 1'b1, 0));

        // ALU chain
        doReset(r);
        applyStimulus(ins(2'd1, 5'd5,  5'd1, 1, 5'd2, 1), 1, ex("alu_c1", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd6,  5'd5, 1, 5'd1, 1), 1, ex("alu_c2", 1, 1, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd7,  5'd5, 1, 5'd2, 1), 1, ex("alu_c3", 2, 1, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd9,  5'd7, 1, 5'd6, 1), 1, ex("alu_c4", 1, 1, 2, 1, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd10, 5'd5, 1, 5'd9, 1), 1, ex("alu_oldest", 4, 1, 1, 1, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd11, 5'd5, 1, 5'd6, 1), 1, ex("alu_retired", 0, 0, 4, 1, 1'b1, 0));

        // Load-use, consumer directly behind the load
        doReset(r);
        applyStimulus(ins(2'd2, 5'd7, 5'd1, 1, 5'd0, 0), 1, ex("lu_load", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1), 1, ex("lu_stall1", 0, 0, 1, 2, 1'b0, 0));
        applyStimulus(ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1), 1, ex("lu_stall2", 0, 0, 2, 2, 1'b0, 1));
        applyStimulus(ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1), 1, ex("lu_fwd", 0, 0, 3, 2, 1'b1, 2));
        applyStimulus(ins(2'd1, 5'd9, 5'd8, 1, 5'd7, 1), 1, ex("lu_after", 1, 1, 4, 2, 1'b1, 2));

        // x0, unused sources and non-writing producers
        doReset(r);
        applyStimulus(ins(2'd1, 5'd0, 5'd1, 1, 5'd2, 1), 1, ex("x0_prod", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd3, 5'd0, 1, 5'd0, 1), 1, ex("x0_src", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd3, 5'd9, 5'd3, 0, 5'd3, 1), 1, ex("unused_src", 0, 0, 1, 1, 1'b1, 0));
        applyStimulus(ins(2'd0, 5'd0, 5'd9, 1, 5'd3, 1), 1, ex("store_no_fwd", 0, 0, 2, 1, 1'b1, 0));
        applyStimulus(ins(2'd2, 5'd0, 5'd1, 1, 5'd2, 1), 1, ex("lw_x0", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd4, 5'd9, 1, 5'd3, 1), 1, ex("ld_rd0_no_stall", 0, 0, 4, 1, 1'b1, 0));

        // Flush during a load-use stall, then a flush while frozen
        doReset(r);
        applyStimulus(ins(2'd2, 5'd7, 5'd1, 1, 5'd0, 0), 1, ex("fl_load", 0, 0, 0, 0, 1'b1, 0));
        v = ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1); v.flush = 1'b1;
        applyStimulus(v, 1, ex("flush_in_stall", 0, 0, 1, 2, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1), 1, ex("flush_restall", 0, 0, 2, 2, 1'b0, 0));
        applyStimulus(ins(2'd1, 5'd8, 5'd1, 1, 5'd7, 1), 1, ex("flush_fwd", 0, 0, 3, 2, 1'b1, 1));
        applyStimulus(ins(2'd1, 5'd9, 5'd8, 1, 5'd0, 0), 1, ex("flush_next", 1, 1, 0, 0, 1'b1, 1));
        v = ins(2'd1, 5'd12, 5'd9, 1, 5'd8, 1); v.flush = 1'b1; v.rdy_d = 1'b0;
        applyStimulus(v, 1, ex("flush_frozen", 1, 1, 2, 1, 1'b1, 1));
        applyStimulus(ins(2'd1, 5'd12, 5'd9, 1, 5'd8, 1), 1, ex("flush_cleared_e0", 0, 0, 2, 1, 1'b1, 1));

        // Freeze mid-chain, then freeze with a hazard pending, then counter saturation
        doReset(r);
        applyStimulus(ins(2'd1, 5'd5, 5'd1, 1, 5'd2, 1), 1, ex("fz_c1", 0, 0, 0, 0, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd6, 5'd5, 1, 5'd1, 1), 1, ex("fz_c2", 1, 1, 0, 0, 1'b1, 0));
        for (int k = 0; k < 3; k++) begin
            v = ins(2'd1, 5'd7, 5'd5, 1, 5'd6, 1); v.rdy_d = 1'b0;
            applyStimulus(v, 1, ex("freeze_hold", 2, 1, 1, 1, 1'b1, 0));
        end
        applyStimulus(ins(2'd1, 5'd7, 5'd5, 1, 5'd6, 1), 1, ex("freeze_resume", 2, 1, 1, 1, 1'b1, 0));
        applyStimulus(ins(2'd1, 5'd8, 5'd7, 1, 5'd5, 1), 1, ex("freeze_after", 1, 1, 3, 1, 1'b1, 0));
        applyStimulus(ins(2'd2, 5'd4, 5'd1, 0, 5'd2, 0), 1, ex("fz_load", 0, 0, 0, 0, 1'b1, 0));
        for (int k = 0; k < 2; k++) begin
            v = ins(2'd1, 5'd10, 5'd4, 1, 5'd6, 1); v.rdy_d = 1'b0;
            applyStimulus(v, 1, ex("freeze_hazard_d", 1, 2, 4, 1, 1'b0, 0));
        end
        v = ins(2'd1, 5'd10, 5'd4, 1, 5'd6, 1); v.rdy_i = 1'b0;
        applyStimulus(v, 1, ex("freeze_hazard_i", 1, 2, 4, 1, 1'b0, 0));
        applyStimulus(ins(2'd1, 5'd10, 5'd4, 1, 5'd6, 1), 1, ex("hz_stall1", 1, 2, 4, 1, 1'b0, 0));
        applyStimulus(ins(2'd1, 5'd10, 5'd4, 1, 5'd6, 1), 1, ex("hz_stall2", 2, 2, 0, 0, 1'b0, 1));
        applyStimulus(ins(2'd1, 5'd10, 5'd4, 1, 5'd6, 1), 1, ex("hz_fwd", 3, 2, 0, 0, 1'b1, 2));
        applyStimulus(ins(2'd2, 5'd11, 5'd0, 0, 5'd0, 0), 1, ex("sat_load", 0, 0, 0, 0, 1'b1, 2));
        applyStimulus(ins(2'd1, 5'd12, 5'd11, 1, 5'd10, 1), 1, ex("sat_stall1", 1, 2, 2, 1, 1'b0, 2));
        applyStimulus(ins(2'd1, 5'd12, 5'd11, 1, 5'd10, 1), 1, ex("sat_stall2", 2, 2, 3, 1, 1'b0, 3));
        applyStimulus(ins(2'd1, 5'd12, 5'd11, 1, 5'd10, 1), 1, ex("sat_fwd", 3, 2, 4, 1, 1'b1, 4));

        @(posedge clk);
        #1;
        strobe = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
